// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : MAR/MDR plus synchronous word memory answering controller
//             access strobes with a fixed-latency one-cycle mem_ready pulse.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              MDR_tobusin,
    input  logic              MDROutEn,
    input  logic              EN,
    input  logic              RW,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              mem_ready,
    output logic              busy,
    output logic              addr_err
);

    localparam int                CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_perform;
    logic                w_in_range;

    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_addr_err;
    logic                r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_perform   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (EN) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_perform   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = EN ? S_HOLD : S_IDLE;
            S_HOLD: begin
                if (!EN) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_in_range = ({1'b0, r_addr} < c_depth);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
            r_op       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            // Access snapshot uses the pre-edge MAR/MDR, so same-edge loads
            // affect only the next access.
            if (w_accept) begin
                r_op       <= RW;
                r_addr     <= r_mar;
                r_wdata    <= r_mdr;
                r_cnt      <= c_cnt_init;
                r_addr_err <= 1'b0;
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_perform) begin
                if (!w_in_range) begin
                    r_rdata    <= '0;
                    r_addr_err <= 1'b1;
                end else if (r_op) begin
                    r_rdata <= r_mem[r_addr];
                end
            end

            if (MARin && r_state != S_BUSY) begin
                r_mar <= bus_in[ADDR_W-1:0];
            end

            if (MDR_tobusin) begin
                r_mdr <= r_rdata;
            end else if (MDRin) begin
                r_mdr <= bus_in;
            end
        end
    end

    // Storage is deliberately unreset; a reset before the perform edge
    // drops the state out of BUSY and so suppresses the write.
    always_ff @(posedge clk) begin
        if (w_perform && !r_op && w_in_range) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus_out   = MDROutEn ? r_mdr : '0;
    assign bus_oe    = MDROutEn;
    assign mem_ready = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Directed self-checking bench for mem_responder (DEPTH=48,
//             LATENCY=2) with a read-data scoreboard and reference memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 48;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] bus_in = '0;
    logic              MARin = 1'b0;
    logic              MDRin = 1'b0;
    logic              MDR_tobusin = 1'b0;
    logic              MDROutEn = 1'b0;
    logic              EN = 1'b0;
    logic              RW = 1'b0;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              mem_ready;
    logic              busy;
    logic              addr_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] cur_mar = '0;
    logic [DATA_W-1:0] cur_mdr = '0;
    int                pulses;

    mem_responder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .MDR_tobusin(MDR_tobusin),
        .MDROutEn   (MDROutEn),
        .EN         (EN),
        .RW         (RW),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mar(input logic [DATA_W-1:0] v);
        MARin  = 1'b1;
        bus_in = v;
        cyc();
        MARin   = 1'b0;
        cur_mar = v[ADDR_W-1:0];
    endtask

    task automatic set_mdr(input logic [DATA_W-1:0] v);
        MDRin  = 1'b1;
        bus_in = v;
        cyc();
        MDRin   = 1'b0;
        cur_mdr = v;
    endtask

    // One complete access with EN pulsed for a single cycle; optionally
    // pulls the read data through MDR onto the bus and scores it.
    task automatic access(input logic rw, input logic exp_err, input logic load);
        logic [DATA_W-1:0] exp;
        EN = 1'b1;
        RW = rw;
        if (rw && load) begin
            exp_q.push_back((int'(cur_mar) < DEPTH) ? ref_mem[cur_mar] : '0);
        end else if (!rw && int'(cur_mar) < DEPTH) begin
            ref_mem[cur_mar] = cur_mdr;
        end
        cyc();
        EN = 1'b0;
        RW = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_err_clear", addr_err, 0);
        check("accept_not_ready", mem_ready, 0);
        for (int i = 1; i < LATENCY; i++) begin
            cyc();
            check("busy_hold", busy, 1);
            check("ready_early", mem_ready, 0);
        end
        cyc();
        check("ready_pulse", mem_ready, 1);
        check("busy_done", busy, 0);
        check("addr_err", addr_err, exp_err);
        MDR_tobusin = load;
        cyc();
        MDR_tobusin = 1'b0;
        check("ready_one_cycle", mem_ready, 0);
        if (load) begin
            MDROutEn = 1'b1;
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                exp = exp_q.pop_front();
                check("read_data", bus_out, exp);
                check("read_oe", bus_oe, 1);
                cur_mdr = exp;
            end
            MDROutEn = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held, then released
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_bus_out", bus_out, 0);
        rst = 1'b1;
        cyc();
        check("rel_busy", busy, 0);
        check("rel_ready", mem_ready, 0);
        check("rel_addr_err", addr_err, 0);
        check("rel_bus_oe", bus_oe, 0);
        set_mar(8'h05);
        MDROutEn = 1'b1;
        #1;
        check("rel_mdr_zero", bus_out, 8'h00);
        check("rel_oe", bus_oe, 1);
        MDROutEn = 1'b0;

        // Write then read back 0x05
        set_mdr(8'hA7);
        access(1'b0, 1'b0, 1'b0);
        set_mdr(8'h00);
        access(1'b1, 1'b0, 1'b1);

        // Held EN yields one pulse until EN drops
        pulses = 0;
        EN = 1'b1;
        RW = 1'b1;
        repeat (10) begin
            cyc();
            if (mem_ready) pulses++;
        end
        EN = 1'b0;
        cyc();
        check("held_pulses", pulses, 1);
        pulses = 0;
        EN = 1'b1;
        repeat (6) begin
            cyc();
            if (mem_ready) pulses++;
        end
        EN = 1'b0;
        RW = 1'b0;
        cyc();
        cyc();
        check("reassert_pulses", pulses, 1);
        check("reassert_idle", busy, 0);

        // Out-of-range write and read, then a valid access clears addr_err
        set_mar(8'h30);
        set_mdr(8'h3F);
        access(1'b0, 1'b1, 1'b0);
        set_mdr(8'hEE);
        access(1'b1, 1'b1, 1'b1);
        set_mar(8'h05);
        access(1'b1, 1'b0, 1'b1);

        // Reset in the middle of a write
        set_mar(8'h02);
        set_mdr(8'h11);
        access(1'b0, 1'b0, 1'b0);
        set_mdr(8'h99);
        EN = 1'b1;
        RW = 1'b0;
        cyc();
        EN = 1'b0;
        cyc();
        rst      = 1'b0;
        MDROutEn = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", mem_ready, 0);
        check("midrst_addr_err", addr_err, 0);
        check("midrst_bus_out", bus_out, 0);
        MDROutEn = 1'b0;
        cyc();
        cyc();
        rst     = 1'b1;
        cur_mar = '0;
        cur_mdr = '0;
        cyc();
        set_mar(8'h02);
        access(1'b1, 1'b0, 1'b1);

        // MAR/MDR strobes while a write is in flight
        set_mar(8'h09);
        set_mdr(8'h12);
        access(1'b0, 1'b0, 1'b0);
        set_mar(8'h07);
        set_mdr(8'h3C);
        ref_mem[7] = 8'h3C;
        EN = 1'b1;
        RW = 1'b0;
        cyc();
        EN = 1'b0;
        check("intf_busy0", busy, 1);
        MARin  = 1'b1;
        bus_in = 8'h09;
        cyc();
        MARin = 1'b0;
        check("intf_busy1", busy, 1);
        MDRin  = 1'b1;
        bus_in = 8'h55;
        cyc();
        MDRin   = 1'b0;
        cur_mdr = 8'h55;
        check("intf_ready", mem_ready, 1);
        MDROutEn = 1'b1;
        #1;
        check("intf_mdr_new", bus_out, 8'h55);
        MDROutEn = 1'b0;
        cyc();
        access(1'b1, 1'b0, 1'b1);
        set_mar(8'h09);
        access(1'b1, 1'b0, 1'b1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
